// File: rtl/host_cmd_sequencer_if.sv
// Bundle of the host request/response handshake and the command bus toward the SoC top.
// The sequencer connects through the slave modport. The master modport is the surrounding
// environment: the host issuing requests and the SoC top answering them.
interface host_cmd_sequencer_if #(
  parameter int HOST_INSTRUCT_SIZE   = 4,
  parameter int MAX_INPUT_DATA_SIZE  = 256,
  parameter int MAX_OUTPUT_DATA_SIZE = 256,
  parameter int TAG_W                = 4,
  parameter int FIFO_DEPTH           = 4
);
  // host request side
  logic                            req_valid;
  logic                            req_ready;
  logic [HOST_INSTRUCT_SIZE-1:0]   req_instr;
  logic [MAX_INPUT_DATA_SIZE-1:0]  req_data;
  logic [TAG_W-1:0]                req_tag;

  // host response side
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [MAX_OUTPUT_DATA_SIZE-1:0] rsp_data;
  logic [TAG_W-1:0]                rsp_tag;
  logic                            rsp_timeout;

  // status
  logic                            busy;
  logic [$clog2(FIFO_DEPTH):0]     pending;

  // command bus toward the SoC top
  logic [HOST_INSTRUCT_SIZE-1:0]   host_instruction;
  logic [MAX_INPUT_DATA_SIZE-1:0]  host_data;
  logic                            start;
  logic [MAX_OUTPUT_DATA_SIZE-1:0] out;
  logic                            operation_done;

  modport slave (
    input  req_valid, req_instr, req_data, req_tag,
    input  rsp_ready,
    input  out, operation_done,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_timeout,
    output busy, pending,
    output host_instruction, host_data, start
  );

  modport master (
    output req_valid, req_instr, req_data, req_tag,
    output rsp_ready,
    output out, operation_done,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_timeout,
    input  busy, pending,
    input  host_instruction, host_data, start
  );
endinterface

// File: rtl/host_cmd_sequencer.sv
// Host-side command sequencer. Requests are queued in a small FIFO and issued one at a time
// to the SoC top as a start pulse with instruction/data. The sequencer then waits for
// operation_done (bounded by a watchdog), captures the result and returns it with the
// request tag. Only one request is ever outstanding, so responses come back in order.
module host_cmd_sequencer #(
  parameter int HOST_INSTRUCT_SIZE   = 4,
  parameter int MAX_INPUT_DATA_SIZE  = 256,
  parameter int MAX_OUTPUT_DATA_SIZE = 256,
  parameter int TAG_W                = 4,
  parameter int FIFO_DEPTH           = 4,
  parameter int TIMEOUT_CYCLES       = 4096
) (
  input logic                 clk,
  input logic                 rst,
  host_cmd_sequencer_if.slave bus
);

  // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // watchdog only needs to reach TIMEOUT_CYCLES-1
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [HOST_INSTRUCT_SIZE-1:0]  instr_mem [FIFO_DEPTH];
  logic [MAX_INPUT_DATA_SIZE-1:0] data_mem  [FIFO_DEPTH];
  logic [TAG_W-1:0]               tag_mem   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             req_ready_reg;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ---------------------------------------------------------------------------
  state_t                          state_reg;
  logic [TAG_W-1:0]                cur_tag_reg;
  logic [WD_W-1:0]                 watchdog_reg;
  logic                            start_reg;
  logic                            busy_reg;
  logic [HOST_INSTRUCT_SIZE-1:0]   host_instruction_reg;
  logic [MAX_INPUT_DATA_SIZE-1:0]  host_data_reg;
  logic                            rsp_valid_reg;
  logic [MAX_OUTPUT_DATA_SIZE-1:0] rsp_data_reg;
  logic [TAG_W-1:0]                rsp_tag_reg;
  logic                            rsp_timeout_reg;

  // req_ready is registered as !full, so a full FIFO refuses a push even when a pop
  // happens in the same cycle
  assign push = bus.req_valid && req_ready_reg;
  // the sequencer takes the head whenever it is idle and something is queued
  assign pop  = (state_reg == IDLE) && (count_reg != '0);

  // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // FIFO storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= bus.req_instr;
      data_mem[wr_ptr_reg]  <= bus.req_data;
      tag_mem[wr_ptr_reg]   <= bus.req_tag;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      req_ready_reg <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg     <= count_next;
      req_ready_reg <= (count_next != FULL_COUNT);
    end
  end

  // Issue/wait/respond sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      cur_tag_reg          <= '0;
      watchdog_reg         <= '0;
      start_reg            <= 1'b0;
      busy_reg             <= 1'b0;
      host_instruction_reg <= '0;
      host_data_reg        <= '0;
      rsp_valid_reg        <= 1'b0;
      rsp_data_reg         <= '0;
      rsp_tag_reg          <= '0;
      rsp_timeout_reg      <= 1'b0;
    end else begin
      // start is a single-cycle pulse that is only raised on entry to ISSUE
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            // the command bus takes the new request here and then holds it until
            // the next issue, so it is already valid during the start cycle
            host_instruction_reg <= instr_mem[rd_ptr_reg];
            host_data_reg        <= data_mem[rd_ptr_reg];
            cur_tag_reg          <= tag_mem[rd_ptr_reg];
            start_reg            <= 1'b1;
            busy_reg             <= 1'b1;
            state_reg            <= ISSUE;
          end
        end
        ISSUE: begin
          // operation_done is deliberately not looked at in this cycle
          watchdog_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          watchdog_reg <= watchdog_reg + WD_W'(1);
          // done has priority over the watchdog terminal count
          if (bus.operation_done) begin
            rsp_data_reg    <= bus.out;
            rsp_timeout_reg <= 1'b0;
            rsp_tag_reg     <= cur_tag_reg;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
          end else if (watchdog_reg == WD_LAST) begin
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b1;
            rsp_tag_reg     <= cur_tag_reg;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
          end
        end
        RESP: begin
          // response fields stay frozen until the host takes them
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_reg;
  assign bus.pending          = count_reg;
  assign bus.busy             = busy_reg;
  assign bus.start            = start_reg;
  assign bus.host_instruction = host_instruction_reg;
  assign bus.host_data        = host_data_reg;
  assign bus.rsp_valid        = rsp_valid_reg;
  assign bus.rsp_data         = rsp_data_reg;
  assign bus.rsp_tag          = rsp_tag_reg;
  assign bus.rsp_timeout      = rsp_timeout_reg;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Bench for host_cmd_sequencer. The stimulus process pushes each request together with the
// expected response (scoreboard queue) and the behaviour the modelled SoC top should show.
// A responder process plays the SoC top; a monitor process checks each response.
// The watchdog is shortened to 16 cycles here, so the single-op case raises done 12
// cycles after start to stay inside the window.
`timescale 1ns/1ps
module tb_host_cmd_sequencer;
  localparam int IW = 4;
  localparam int DW = 256;
  localparam int OW = 256;
  localparam int TW = 4;
  localparam int FD = 4;
  localparam int TO = 16;

  localparam logic [OW-1:0] OUT_X = {8{32'hCAFE0001}};
  localparam logic [OW-1:0] OUT_B = {8{32'hB10C0002}};
  localparam logic [OW-1:0] OUT_C = {8{32'h0C0C0003}};
  localparam logic [OW-1:0] OUT_D = {8{32'hD00D0004}};
  localparam logic [OW-1:0] OUT_E = {8{32'hE00E0005}};
  localparam logic [OW-1:0] OUT_F = {8{32'hF00F0006}};
  localparam logic [OW-1:0] OUT_G = {8{32'h60060007}};
  localparam logic [OW-1:0] OUT_H = {8{32'h80080008}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_cmd_sequencer_if #(
    .HOST_INSTRUCT_SIZE(IW), .MAX_INPUT_DATA_SIZE(DW), .MAX_OUTPUT_DATA_SIZE(OW),
    .TAG_W(TW), .FIFO_DEPTH(FD)
  ) bus ();

  host_cmd_sequencer #(
    .HOST_INSTRUCT_SIZE(IW), .MAX_INPUT_DATA_SIZE(DW), .MAX_OUTPUT_DATA_SIZE(OW),
    .TAG_W(TW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic [TW-1:0] tag;
    bit            timeout;
    int            lat;
  } exp_t;

  typedef struct {
    logic [IW-1:0] instr;
    logic [DW-1:0] data;
    int            delay;
    bit            do_done;
    logic [OW-1:0] out_val;
  } beh_t;

  exp_t exp_q[$];
  beh_t beh_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_count = 0;
  int start_cyc = 0;
  int accept_cyc = 0;
  int rsp_seen = 0;

  logic          resp_done = 1'b0;
  logic          idle_done = 1'b0;
  logic [OW-1:0] resp_out = '0;
  logic [OW-1:0] idle_out = '0;
  assign bus.operation_done = resp_done | idle_done;
  assign bus.out            = resp_done ? resp_out : idle_out;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not occur in time", name);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // models the SoC top: answers each start pulse as the scheduled behaviour says
  initial begin : responder
    beh_t b;
    forever begin
      @(negedge clk);
      if (!rst && bus.start) begin
        start_count++;
        start_cyc = cyc;
        if (beh_q.size() == 0) begin
          fail_now("unexpected_start");
        end else begin
          b = beh_q.pop_front();
          chk("start_instr", bus.host_instruction, b.instr);
          chk("start_data", bus.host_data, b.data);
          chk("start_no_rsp_valid", bus.rsp_valid, 0);
          if (b.do_done) begin
            repeat (b.delay) @(posedge clk);
            #1;
            resp_out  = b.out_val;
            resp_done = 1'b1;
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            chk("data_held", bus.host_data, b.data);
          end
        end
      end
    end
  end

  // response monitor: pops the scoreboard on each new response
  initial begin : monitor
    exp_t          e;
    bit            in_rsp = 0;
    bit            stable_bad = 0;
    bit            expect_idle = 0;
    logic [OW-1:0] snap_data;
    logic [TW-1:0] snap_tag;
    logic          snap_to;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp      = 0;
        stable_bad  = 0;
        expect_idle = 0;
      end else begin
        if (expect_idle) begin
          chk("hs_then_no_valid", bus.rsp_valid, 0);
          chk("hs_then_idle", bus.busy, 0);
          expect_idle = 0;
        end
        if (bus.rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1;
            rsp_seen++;
            snap_data = bus.rsp_data;
            snap_tag  = bus.rsp_tag;
            snap_to   = bus.rsp_timeout;
            $display("rsp tag=%0d timeout=%0d lat=%0d data=%h", bus.rsp_tag, bus.rsp_timeout,
                     cyc - start_cyc, bus.rsp_data);
            if (exp_q.size() == 0) begin
              fail_now("unexpected_rsp");
            end else begin
              e = exp_q.pop_front();
              chk("rsp_tag", bus.rsp_tag, e.tag);
              chk("rsp_data", bus.rsp_data, e.data);
              chk("rsp_timeout", bus.rsp_timeout, e.timeout);
              chk("rsp_latency", cyc - start_cyc, e.lat);
            end
          end else if (bus.rsp_data !== snap_data || bus.rsp_tag !== snap_tag ||
                       bus.rsp_timeout !== snap_to) begin
            stable_bad = 1;
          end
          if (bus.rsp_ready) begin
            chk("rsp_stable", stable_bad, 0);
            in_rsp      = 0;
            stable_bad  = 0;
            expect_idle = 1;
          end
        end
      end
    end
  end

  task automatic push(input logic [IW-1:0] instr, input logic [DW-1:0] data,
                      input logic [TW-1:0] tag, input int delay, input bit do_done,
                      input logic [OW-1:0] out_val, input logic [OW-1:0] exp_data,
                      input bit exp_to, input int exp_lat);
    beh_t b;
    exp_t e;
    int   n;
    b.instr = instr; b.data = data; b.delay = delay; b.do_done = do_done; b.out_val = out_val;
    e.data = exp_data; e.tag = tag; e.timeout = exp_to; e.lat = exp_lat;
    beh_q.push_back(b);
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_instr = instr;
    bus.req_data  = data;
    bus.req_tag   = tag;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n >= 500) begin
        fail_now("push_accept");
        break;
      end
      @(posedge clk);
      #1;
    end
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    $display("req tag=%0d instr=%h delay=%0d done=%0d", tag, instr, delay, do_done);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 2000 && !(exp_q.size() == 0 && !bus.busy && bus.pending == 0 && !bus.rsp_valid)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now(name);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int s0, input string name);
    int n = 0;
    while (n < 100 && start_count == s0) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now(name);
  endtask

  initial begin : stimulus
    int s0;
    int s1;
    int r0;
    int n;
    int fill_delay[5];
    fill_delay = '{1, 2, 3, 5, 1};
    bus.req_valid = 1'b0;
    bus.req_instr = '0;
    bus.req_data  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_host_instruction", bus.host_instruction, 0);
    chk("rst_host_data", bus.host_data, 0);
    chk("rst_start", bus.start, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;

    // reset while waiting aborts the request without a response
    s0 = start_count;
    push(4'h7, 256'h77, 4'd3, 0, 1'b0, '0, '0, 1'b1, 17);
    wait_start(s0, "abort_start");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_start_low", bus.start, 0);
    chk("abort_pending", bus.pending, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_busy", bus.busy, 0);
    exp_q.delete();
    beh_q.delete();
    r0 = rsp_seen;
    s0 = start_count;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_rsp", rsp_seen - r0, 0);
    chk("abort_no_start", start_count - s0, 0);

    // single operation into an empty FIFO
    s0 = start_count;
    push(4'h1, 256'h00112233, 4'd5, 12, 1'b1, OUT_X, OUT_X, 1'b0, 13);
    wait_idle("single_idle");
    chk("single_start_pulses", start_count - s0, 1);
    chk("issue_latency", start_cyc - accept_cyc, 2);

    // fill the FIFO behind a long-running request; the fifth push stalls
    s0 = start_count;
    push(4'h2, 256'hB10C, 4'd9, 15, 1'b1, OUT_B, OUT_B, 1'b0, 16);
    wait_start(s0, "fill_start");
    for (int i = 0; i < 4; i++) begin
      push(IW'(8 + i), DW'(32'h1000 + i), TW'(i), fill_delay[i], 1'b1,
           OW'(32'hF1110000 + i), OW'(32'hF1110000 + i), 1'b0, fill_delay[i] + 1);
    end
    @(negedge clk);
    chk("fill_pending", bus.pending, 4);
    chk("fill_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    push(4'hC, 256'h1004, 4'd4, fill_delay[4], 1'b1, OW'(32'hF1110004), OW'(32'hF1110004),
         1'b0, fill_delay[4] + 1);
    wait_idle("fill_idle");

    // watchdog expiry, then a queued request still issues
    push(4'h3, 256'hAAAA, 4'd6, 0, 1'b0, '0, '0, 1'b1, 17);
    push(4'h4, 256'hBBBB, 4'd7, 3, 1'b1, OUT_C, OUT_C, 1'b0, 4);
    wait_idle("timeout_idle");

    // done exactly on the terminal watchdog cycle wins; done only during ISSUE is ignored
    push(4'h5, 256'hCCCC, 4'd8, 16, 1'b1, OUT_D, OUT_D, 1'b0, 17);
    push(4'h6, 256'hDDDD, 4'd10, 0, 1'b1, OUT_E, '0, 1'b1, 17);
    wait_idle("terminal_idle");

    // done pulse while idle is ignored
    r0 = rsp_seen;
    s0 = start_count;
    idle_out  = OUT_F;
    idle_done = 1'b1;
    @(posedge clk);
    #1;
    idle_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_done_no_rsp", rsp_seen - r0, 0);
    chk("idle_done_no_start", start_count - s0, 0);
    chk("idle_done_busy", bus.busy, 0);

    // response backpressure holds the response and blocks the next issue
    bus.rsp_ready = 1'b0;
    push(4'h7, 256'hEEEE, 4'd11, 2, 1'b1, OUT_G, OUT_G, 1'b0, 3);
    push(4'h8, 256'hFFFF, 4'd12, 1, 1'b1, OUT_H, OUT_H, 1'b0, 2);
    n = 0;
    while (n < 100 && !bus.rsp_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("bp_rsp_valid");
    s1 = start_count;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_valid_held", bus.rsp_valid, 1);
    chk("bp_tag_held", bus.rsp_tag, 11);
    chk("bp_no_start", start_count - s1, 0);
    chk("bp_busy", bus.busy, 1);
    chk("bp_pending", bus.pending, 1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_idle("bp_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, %0d failures so far", n_fail);
    $fatal(1, "global timeout");
  end

endmodule
